bit_stuffer: RTL

//  Stage directly downstream of the packet bit-stream encoder. It consumes the encoder's serial bit

---
 rtl/usb_pkg.sv | 15 +
 rtl/bit_stuffer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions.
//  stuff_state_t : bit-stuffer FSM states
//  USB_MAX_ONES  : consecutive-ones run length that forces a stuffed 0
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2,
    DONE  = 2'd3
  } stuff_state_t;

  localparam int unsigned USB_MAX_ONES = 6;

endpackage : usb_pkg

// File: rtl/bit_stuffer.sv
// Bit stuffer: inserts a 0 after every MAX_ONES consecutive 1s of the encoder
// stream and stalls the encoder with pause while the stuffed bit goes out.
//  clk        : system clock
//  rst        : synchronous active-high reset
//  start      : 1-cycle packet start pulse; first bit arrives next cycle
//  endr       : encoder has no more bits (level)
//  s_in       : encoder serial bit, taken in RUN when pause==0 and endr==0
//  pause      : combinational encoder stall, high only in STUFF
//  out_bit    : registered stuffed-stream bit
//  out_valid  : out_bit valid this cycle
//  out_first  : first bit of packet (with out_valid)
//  stuff_done : 1-cycle pulse once the last bit is out
module bit_stuffer
  import usb_pkg::*;
#(
  parameter int unsigned MAX_ONES = USB_MAX_ONES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic endr,
  input  logic s_in,
  output logic pause,
  output logic out_bit,
  output logic out_valid,
  output logic out_first,
  output logic stuff_done
);

  localparam int unsigned CNT_W = $clog2(MAX_ONES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ONES - 1);

  stuff_state_t     state, state_nxt;
  logic [CNT_W-1:0] ones_cnt, ones_cnt_nxt;
  logic             first_pend, first_pend_nxt;
  logic             out_bit_nxt, out_valid_nxt, out_first_nxt, stuff_done_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ones_cnt   <= '0;
      first_pend <= 1'b0;
      out_bit    <= 1'b0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      stuff_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      ones_cnt   <= ones_cnt_nxt;
      first_pend <= first_pend_nxt;
      out_bit    <= out_bit_nxt;
      out_valid  <= out_valid_nxt;
      out_first  <= out_first_nxt;
      stuff_done <= stuff_done_nxt;
    end
  end

  // Next state, run-length counter and next registered outputs
  always_comb begin
    state_nxt      = state;
    ones_cnt_nxt   = ones_cnt;
    first_pend_nxt = first_pend;
    out_bit_nxt    = 1'b0;
    out_valid_nxt  = 1'b0;
    out_first_nxt  = 1'b0;
    stuff_done_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = RUN;
          ones_cnt_nxt   = '0;
          first_pend_nxt = 1'b1;
        end
      end

      RUN: begin
        if (endr) begin
          state_nxt = DONE;
        end else if (start) begin
          // Restart: forget the run length, next bit is a new first bit
          ones_cnt_nxt   = '0;
          first_pend_nxt = 1'b1;
        end else begin
          out_bit_nxt    = s_in;
          out_valid_nxt  = 1'b1;
          out_first_nxt  = first_pend;
          first_pend_nxt = 1'b0;
          if (!s_in) begin
            ones_cnt_nxt = '0;
          end else if (ones_cnt == CNT_LAST) begin
            ones_cnt_nxt = '0;
            state_nxt    = STUFF;
          end else begin
            ones_cnt_nxt = ones_cnt + CNT_W'(1);
          end
        end
      end

      // Stuffed 0 is always emitted, even if endr rose meanwhile
      STUFF: begin
        out_valid_nxt = 1'b1;
        state_nxt     = RUN;
      end

      DONE: begin
        stuff_done_nxt = 1'b1;
        state_nxt      = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Encoder stall
  always_comb begin
    pause = 1'b0;
    if (state == STUFF) pause = 1'b1;
  end

endmodule : bit_stuffer
